mfp_reset_sequencer: RTL and testbench
======================================

# mfp_reset_sequencer

Parametrised multi-channel reset sequencer for the MIPSfpga system. It generalises the fixed 16-cycle EJTAG reset pulse into N independent active-low reset outputs, for example EJTAG TRST, core, AHB matrix and peripherals. All channels are held low for a programmable pulse, then released one at a time with a programmable gap. A debounced board button or a single-cycle software request re-runs the whole sequence, and the block records what caused the last reset.

## Interface
Parameters:
- N_CH, 4: number of reset channels; legal range 1..16.
- PULSE_CYCLES, 16: cycles all channels stay low before the first release; must be ≥1.
- STAGE_GAP, 4: cycles between releases of consecutive channels; must be ≥1.
- DEBOUNCE_CYCLES, 8: consecutive stable synchronized samples the button needs; must be ≥2.
- CNT_W, 8: width of the shared counter; must hold max(PULSE_CYCLES, STAGE_GAP, DEBOUNCE_CYCLES).

Ports:
- SI_ClkIn, in, 1: the only clock; all logic is on its rising edge.
- SI_Reset, in, 1: synchronous, active-high reset.
- req_button, in, 1: raw asynchronous push button, active-high.
- req_sw, in, 1: software reset request, single-cycle and synchronous (e.g. MFP_Reset).
- ext_n, in, N_CH: per-channel external active-low reset, e.g. probe TRST; it is ANDed into the output.
- rst_n, out, N_CH: active-low channel resets; channel 0 is released first.
- busy, out, 1: high whenever any internal channel register is still asserted.
- done, out, 1: one-cycle pulse when the last channel is released.
- cause, out, 2: source of the last reset; 0 = SI_Reset, 1 = button, 2 = software.

## Operation
- Output logic: rst_n[i] = ch_q[i] & ext_n[i]. This is the only combinational path.
- FSM states are HOLD, STAGE and RUN, driven by one counter cnt and one channel index idx.
- **SI_Reset high:**
  - state ← HOLD, ch_q ← 0, cnt ← 0, idx ← 0, cause ← 0.
  - Debounce state is cleared and the done register ← 0.
- **HOLD:**
  - cnt increments each cycle.
  - When cnt = PULSE_CYCLES−1: ch_q[0] ← 1, cnt ← 0, idx ← 1.
  - Next state is STAGE, or RUN if N_CH = 1.
- **STAGE:**
  - cnt increments each cycle.
  - When cnt = STAGE_GAP−1: ch_q[idx] ← 1, cnt ← 0, idx ← idx+1.
  - After releasing channel N_CH−1, go to RUN.
- **done:** registered; high for exactly the cycle following the edge that sets the last ch_q bit.
- **RUN:** all ch_q = 1; waits for a request.
- **Request:** req = req_sw | btn_rise.
  - Any request in any state (HOLD, STAGE or RUN) restarts the sequence: ch_q ← 0, cnt ← 0, idx ← 0, state ← HOLD.
  - A restart during HOLD or STAGE restarts the full pulse.
- **cause update:**
  - Updated on every restart: 2 if req_sw is high, otherwise 1.
  - Simultaneous sw and button requests give cause = 2.
  - SI_Reset overrides everything.
- **Button path:**
  - A 2-flop synchronizer feeds the debounce counter.
  - The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from it.
  - Any sample that agrees with the current debounced level clears the counter.
  - btn_rise is a one-cycle pulse on the debounced 0→1 transition.
  - Holding the button produces a single request; releasing it produces no request.

## Timing
- **Reset values:** rst_n = 0 (independent of ext_n); busy = 1; done = 0; cause = 0.
- **Edge numbering:** edge 0 is the first rising edge at which SI_Reset is sampled low. rst_n[i] rises after edge PULSE_CYCLES−1 + i·STAGE_GAP.
  - With defaults, channel release edges are 15, 19, 23 and 27.
  - done is high in the cycle after edge 27.
  - busy falls together with the last release.
- **Software request:** req_sw high at edge k drives all rst_n low after edge k. The new sequence counts from edge k+1.
- **Button, accepted press:** a press held stable is accepted ≤ DEBOUNCE_CYCLES+3 edges after it rises.
- **Button, rejected glitch:** a glitch shorter than DEBOUNCE_CYCLES−1 cycles never triggers a restart.
- **ext_n low:** forces the matching rst_n low in the same cycle. It never affects the FSM, busy or done.
- **Counter wrap:** cnt never exceeds its terminal value and never wraps.

## Test plan
- **Power-up sequence:** defaults, SI_Reset high for 3 cycles then low, ext_n = 4'hF.
  - rst_n = 0 through edge 14, then 4'h1 at edge 15, 4'h3 at edge 19, 4'h7 at edge 23, 4'hF at edge 27.
  - done pulses once; busy 1→0 at edge 27; cause = 0.
- **Software reset in RUN:** req_sw one cycle at edge k.
  - rst_n = 0 after edge k; the staged release repeats at k+16, k+20, k+24, k+28.
  - cause = 2.
- **Button debounce:**
  - Button pulses of 5 cycles produce no restart.
  - Button held 40 cycles produces exactly one restart, starting ≤ 11 edges after the rise, with cause = 1.
  - Releasing the button produces no further restart.
- **Restart mid-sequence:** req_sw at edge 21, while channels 0–1 are released.
  - All channels drop; channel 0 re-releases 16 cycles later.
  - done fires only once, at the end of the new sequence.
- **Simultaneous events:**
  - req_sw together with btn_rise gives a single restart with cause = 2.
  - SI_Reset asserted mid-STAGE gives rst_n = 0 next cycle and cause = 0.
- **ext_n masking and N_CH = 1:**
  - ext_n[2] = 0 in RUN gives rst_n = 4'hB, busy = 0, and no restart.
  - With N_CH = 1 and PULSE_CYCLES = 1: rst_n rises after edge 0 and done pulses in the next cycle.

Source files
------------

// File: rtl/mfp_reset_sequencer.sv
// mfp_reset_sequencer
// Staged multi-channel active-low reset generator. All channels are held low
// for a programmable pulse and then released one at a time, channel 0 first,
// with a programmable gap between releases. A debounced board button or a
// single-cycle software request re-runs the whole sequence, and the block
// records which source caused the most recent reset.
module mfp_reset_sequencer #(
    parameter int N_CH            = 4,
    parameter int PULSE_CYCLES    = 16,
    parameter int STAGE_GAP       = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic            SI_ClkIn,
    input  logic            SI_Reset,
    input  logic            req_button,
    input  logic            req_sw,
    input  logic [N_CH-1:0] ext_n,
    output logic [N_CH-1:0] rst_n,
    output logic            busy,
    output logic            done,
    output logic [1:0]      cause
);

    // The channel index has to count up to N_CH (16 max), so 5 bits suffice.
    localparam int IDX_W = 5;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_CH - 1);
    localparam logic [N_CH-1:0]  CH_NONE    = {N_CH{1'b0}};
    localparam logic [N_CH-1:0]  CH_ALL     = {N_CH{1'b1}};
    localparam logic [N_CH-1:0]  CH_ONE     = N_CH'(1'b1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [N_CH-1:0]   ch_q_r;
    logic              busy_r;
    logic              done_r;
    logic [1:0]        cause_r;

    logic              btn_meta_r;
    logic              btn_sync_r;
    logic              btn_db_r;
    logic              btn_rise_r;
    logic [CNT_W-1:0]  db_cnt_r;

    logic              req_s;

    // Either request source restarts the sequence; btn_rise_r is already a
    // registered single-cycle pulse.
    assign req_s = req_sw | btn_rise_r;

    // External resets (e.g. probe TRST) are ANDed in without touching the FSM.
    assign rst_n = ch_q_r & ext_n;
    assign busy  = busy_r;
    assign done  = done_r;
    assign cause = cause_r;

    // Button path: two-flop synchronizer, then a debouncer that flips its
    // level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            btn_db_r   <= 1'b0;
            btn_rise_r <= 1'b0;
            db_cnt_r   <= CNT_ZERO;
        end else begin
            btn_meta_r <= req_button;
            btn_sync_r <= btn_meta_r;
            btn_rise_r <= 1'b0;
            if (btn_sync_r != btn_db_r) begin
                if (db_cnt_r == DB_LAST) begin
                    btn_db_r   <= btn_sync_r;
                    btn_rise_r <= btn_sync_r;
                    db_cnt_r   <= CNT_ZERO;
                end else begin
                    db_cnt_r <= db_cnt_r + CNT_ONE;
                end
            end else begin
                db_cnt_r <= CNT_ZERO;
            end
        end
    end

    // Sequencing FSM: hold all channels, then release them one per gap;
    // any request restarts the full pulse from whatever state we are in.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            state_r <= ST_HOLD;
            ch_q_r  <= CH_NONE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 5'd0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            cause_r <= 2'd0;
        end else if (req_s) begin
            state_r <= ST_HOLD;
            ch_q_r  <= CH_NONE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 5'd0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            cause_r <= req_sw ? 2'd2 : 2'd1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_HOLD: begin
                    if (cnt_r == PULSE_LAST) begin
                        ch_q_r <= ch_q_r | CH_ONE;
                        cnt_r  <= CNT_ZERO;
                        idx_r  <= 5'd1;
                        if (N_CH == 1) begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_STAGE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_STAGE: begin
                    if (cnt_r == GAP_LAST) begin
                        ch_q_r <= ch_q_r | (CH_ONE << idx_r);
                        cnt_r  <= CNT_ZERO;
                        idx_r  <= idx_r + 5'd1;
                        if (idx_r == IDX_LAST) begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_STAGE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    ch_q_r <= CH_ALL;
                    cnt_r  <= CNT_ZERO;
                    busy_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_HOLD;
                    ch_q_r  <= CH_NONE;
                    cnt_r   <= CNT_ZERO;
                    idx_r   <= 5'd0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_reset_sequencer.sv
// tb_mfp_reset_sequencer
// Directed scenarios plus a randomized phase, all compared cycle by cycle
// against a timeline model of the reset sequence.
module tb_mfp_reset_sequencer;

    localparam int N = 4;
    localparam int P = 16;
    localparam int G = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       si_reset   = 1'b1;
    logic       req_button = 1'b0;
    logic       req_sw     = 1'b0;
    logic [3:0] ext_n      = 4'hF;
    logic [3:0] rst_n;
    logic       busy;
    logic       done;
    logic [1:0] cause;

    logic       si_reset1   = 1'b1;
    logic       req_button1 = 1'b0;
    logic       req_sw1     = 1'b0;
    logic [0:0] ext1_n      = 1'b1;
    logic [0:0] rst1_n;
    logic       busy1;
    logic       done1;
    logic [1:0] cause1;

    mfp_reset_sequencer #(.N_CH(4), .PULSE_CYCLES(16), .STAGE_GAP(4),
                          .DEBOUNCE_CYCLES(8), .CNT_W(8)) dut (
        .SI_ClkIn(clk), .SI_Reset(si_reset), .req_button(req_button),
        .req_sw(req_sw), .ext_n(ext_n), .rst_n(rst_n), .busy(busy),
        .done(done), .cause(cause));

    mfp_reset_sequencer #(.N_CH(1), .PULSE_CYCLES(1), .STAGE_GAP(4),
                          .DEBOUNCE_CYCLES(8), .CNT_W(8)) dut1 (
        .SI_ClkIn(clk), .SI_Reset(si_reset1), .req_button(req_button1),
        .req_sw(req_sw1), .ext_n(ext1_n), .rst_n(rst1_n), .busy(busy1),
        .done(done1), .cause(cause1));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a sequence is described only by the edge it starts
    // counting from; outputs follow from plain arithmetic on the edge number.
    int e_now   = -1;
    int m_start = 1000000;
    int m_cause = 0;
    bit m_pipe0 = 1'b0;
    bit m_pipe1 = 1'b0;
    bit m_db    = 1'b0;
    bit m_rise  = 1'b0;
    bit win[$];

    int done_seen     = 0;
    int restarts_seen = 0;
    bit prev_busy     = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e_now);
        end
    endtask

    function automatic int released(input int e);
        int r;
        if (e < m_start + P - 1) return 0;
        r = (e - (m_start + P - 1)) / G + 1;
        return (r > N) ? N : r;
    endfunction

    task automatic model_update();
        bit s;
        bit new_rise;
        bit all_differ;
        e_now++;
        new_rise = 1'b0;
        if (si_reset) begin
            m_start = e_now + 1;
            m_cause = 0;
            m_pipe0 = 1'b0;
            m_pipe1 = 1'b0;
            m_db    = 1'b0;
            m_rise  = 1'b0;
            win.delete();
        end else begin
            if (req_sw || m_rise) begin
                m_start = e_now + 1;
                m_cause = req_sw ? 2 : 1;
            end
            s = m_pipe1;
            m_pipe1 = m_pipe0;
            m_pipe0 = req_button;
            win.push_back(s);
            if (win.size() > D) void'(win.pop_front());
            if (win.size() == D) begin
                all_differ = 1'b1;
                foreach (win[i]) if (win[i] == m_db) all_differ = 1'b0;
                if (all_differ) begin
                    m_db     = s;
                    new_rise = s;
                end
            end
            m_rise = new_rise;
        end
    endtask

    task automatic check_outputs();
        int r;
        logic [31:0] mask;
        r    = released(e_now);
        mask = (32'd1 << r) - 32'd1;
        check_val("rst_n", {28'd0, rst_n}, {28'd0, mask[3:0] & ext_n});
        check_val("busy", {31'd0, busy}, (r < N) ? 32'd1 : 32'd0);
        check_val("done", {31'd0, done},
                  (r == N && e_now == m_start + P - 1 + (N - 1) * G) ? 32'd1 : 32'd0);
        check_val("cause", {30'd0, cause}, m_cause);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
        if (done === 1'b1) done_seen++;
        if (busy === 1'b1 && prev_busy == 1'b0) restarts_seen++;
        prev_busy = busy;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int a;
        int run;

        // Power-up
        steps(3);
        si_reset  = 1'b0;
        done_seen = 0;
        steps(32);
        check_val("pwr_final", {28'd0, rst_n}, 32'hF);
        check_val("pwr_cause", {30'd0, cause}, 32'd0);
        check_val("pwr_done_cnt", done_seen, 32'd1);

        // Software reset in RUN
        req_sw = 1'b1;
        step();
        req_sw = 1'b0;
        check_val("sw_drop", {28'd0, rst_n}, 32'd0);
        check_val("sw_cause", {30'd0, cause}, 32'd2);
        steps(30);
        check_val("sw_final", {28'd0, rst_n}, 32'hF);

        // Short button pulses must be rejected
        restarts_seen = 0;
        for (int k = 0; k < 3; k++) begin
            req_button = 1'b1;
            steps(5);
            req_button = 1'b0;
            steps(12);
        end
        check_val("glitch_restarts", restarts_seen, 32'd0);

        // Held button: exactly one restart, release gives none
        restarts_seen = 0;
        lat = -1;
        a = e_now + 1;
        req_button = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (busy === 1'b1 && lat < 0) lat = e_now - a;
        end
        check_val("hold_cause", {30'd0, cause}, 32'd1);
        req_button = 1'b0;
        steps(40);
        check_val("hold_restarts", restarts_seen, 32'd1);
        check_val("hold_latency_ok", (lat >= 0 && lat <= 11) ? 32'd1 : 32'd0, 32'd1);

        // Restart mid-sequence at relative edge 21
        req_sw = 1'b1;
        step();
        req_sw = 1'b0;
        for (int k = 0; k < 40 && (e_now + 1 < m_start + 21); k++) step();
        check_val("mid_pre", {28'd0, rst_n}, 32'h3);
        done_seen = 0;
        req_sw = 1'b1;
        step();
        req_sw = 1'b0;
        check_val("mid_drop", {28'd0, rst_n}, 32'd0);
        steps(40);
        check_val("mid_done_cnt", done_seen, 32'd1);

        // Software request coinciding with a debounced button rise
        restarts_seen = 0;
        req_button = 1'b1;
        for (int k = 0; k < 20 && !m_rise; k++) step();
        req_sw = 1'b1;
        step();
        req_sw = 1'b0;
        check_val("sim_cause", {30'd0, cause}, 32'd2);
        req_button = 1'b0;
        steps(40);
        check_val("sim_restarts", restarts_seen, 32'd1);

        // SI_Reset while in STAGE
        req_sw = 1'b1;
        step();
        req_sw = 1'b0;
        for (int k = 0; k < 40 && (e_now + 1 < m_start + 17); k++) step();
        si_reset = 1'b1;
        step();
        si_reset = 1'b0;
        check_val("stage_rst_rst_n", {28'd0, rst_n}, 32'd0);
        check_val("stage_rst_cause", {30'd0, cause}, 32'd0);
        steps(35);

        // ext_n masking in RUN
        restarts_seen = 0;
        ext_n = 4'hB;
        #1;
        check_val("ext_same_cycle", {28'd0, rst_n}, 32'hB);
        steps(10);
        check_val("ext_busy", {31'd0, busy}, 32'd0);
        check_val("ext_restarts", restarts_seen, 32'd0);
        ext_n = 4'hF;

        // Single channel, one-cycle pulse
        check_val("one_rst_rst_n", {31'd0, rst1_n}, 32'd0);
        check_val("one_rst_busy", {31'd0, busy1}, 32'd1);
        si_reset1 = 1'b0;
        step();
        check_val("one_rel", {31'd0, rst1_n}, 32'd1);
        check_val("one_done", {31'd0, done1}, 32'd1);
        check_val("one_busy", {31'd0, busy1}, 32'd0);
        step();
        check_val("one_done_end", {31'd0, done1}, 32'd0);
        req_sw1 = 1'b1;
        step();
        req_sw1 = 1'b0;
        check_val("one_sw_drop", {31'd0, rst1_n}, 32'd0);
        check_val("one_sw_cause", {30'd0, cause1}, 32'd2);
        step();
        check_val("one_sw_rel", {31'd0, rst1_n}, 32'd1);
        check_val("one_sw_done", {31'd0, done1}, 32'd1);

        // Randomized traffic
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                req_button = ~req_button;
                run = $urandom_range(1, 20);
            end
            run--;
            req_sw   = ($urandom_range(0, 63) == 0);
            si_reset = ($urandom_range(0, 499) == 0);
            ext_n    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
